fetch_unit: RTL

Decoupled instruction-fetch front end for the five-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline registers. It owns the program counter, issues word fetches to a variable-latency instruction memory, and buffers returned {pc_plus_four, instruction} pairs in a small queue. The IF/ID stage drains the queue through a valid/ready handshake. A branch redirect from the MEM stage flushes the queue and restarts fetch at the branch target.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, queue entry layout and PC helper for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0]    PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc_plus_four;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc+4, instruction} pairs; head is read combinationally.
// Flush wins over push/pop; the caller guarantees no push when full and no pop when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the read side is qualified by count.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Decoupled IF front end: PC, single-outstanding imem request tracking, stale-response drop, output queue.
// Define FETCH_UNIT_BYPASS_EN to forward a response straight to the consumer when the queue is empty.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instruction,
  output logic [PC_W-1:0]        out_pc_plus_four,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;

  logic             push, pop, issue, bypass;
  logic             q_push, q_pop, q_empty, space_ok;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ_after_push, occ_limit;
  fetch_entry_t     head_entry, resp_entry, out_entry;

  assign resp_entry = '{pc_plus_four: pc_next(addr_q), instr: imem_rdata};

  // The reset term keeps the combinational outputs quiet while reset is held.
  assign push = reset && imem_rvalid && !drop_q && !redirect;

`ifdef FETCH_UNIT_BYPASS_EN
  assign bypass = q_empty && push && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !q_empty || bypass;
  assign pop       = out_valid && out_ready && !redirect;
  assign q_push    = push && !bypass;
  assign q_pop     = pop && !bypass;

  // Issue only if the response is guaranteed a slot: count + push - pop < DEPTH.
  assign occ_after_push = {1'b0, count} + {{CNT_W{1'b0}}, push};
  assign occ_limit      = (CNT_W+1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
  assign space_ok       = occ_after_push < occ_limit;

  assign issue     = reset && !redirect && (!outstanding_q || imem_rvalid) && space_ok;
  assign imem_req  = issue;
  assign imem_addr = issue ? fetch_pc_q : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    addr_d        = addr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect) begin
      fetch_pc_d    = redirect_pc;
      outstanding_d = outstanding_q && !imem_rvalid;
      drop_d        = outstanding_q && !imem_rvalid;
    end else begin
      if (imem_rvalid && drop_q) drop_d = 1'b0;
      if (issue) begin
        addr_d        = fetch_pc_q;
        fetch_pc_d    = pc_next(fetch_pc_q);
        outstanding_d = 1'b1;
      end else if (imem_rvalid) begin
        outstanding_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      addr_q        <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (redirect),
    .push_i  (q_push),
    .wdata_i (resp_entry),
    .pop_i   (q_pop),
    .rdata_o (head_entry),
    .count_o (count),
    .empty_o (q_empty)
  );

  assign out_entry        = bypass ? resp_entry : head_entry;
  assign out_instruction  = out_valid ? out_entry.instr : NOP_INSTR;
  assign out_pc_plus_four = out_valid ? out_entry.pc_plus_four : '0;
  assign occupancy        = count;

endmodule
